muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M sequencer: shift-add multiply and restoring divide on operand
// magnitudes, then a single sign-fix cycle before presenting the result.
module muldiv_sequencer #(
    parameter int XLEN      = 32,
    parameter bit DIVZ_FAST = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            busy,
    output logic            stall_o,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    logic [2:0]          r_funct3;
    logic [XLEN-1:0]     r_mag_a;
    logic [XLEN-1:0]     r_mag_b;
    logic [2*XLEN-1:0]   r_prod;
    logic [XLEN-1:0]     r_quo;
    logic [XLEN-1:0]     r_rem;
    logic                r_neg_p;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [CW-1:0]       r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [XLEN-1:0]     r_result;

    function automatic logic [XLEN-1:0] neg_word(input logic [XLEN-1:0] v, input logic en);
        neg_word = en ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_dword(input logic [2*XLEN-1:0] v, input logic en);
        neg_dword = en ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_sa;
    logic                w_sb;
    logic                w_b_zero;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic [XLEN-1:0]     w_divz_res;
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN:0]       w_div_trial;
    logic [XLEN:0]       w_div_diff;
    logic                w_div_ge;
    logic [XLEN-1:0]     w_rem_next;
    logic [XLEN-1:0]     w_quo_next;
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_quo_fix;
    logic [XLEN-1:0]     w_rem_fix;
    logic [XLEN-1:0]     w_fix_sel;

    // Launch decode: operand signedness, magnitudes and the divide-by-zero shortcut value
    always_comb begin
        w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b110);
        w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        w_sa       = w_a_signed & op_a[XLEN-1];
        w_sb       = w_b_signed & op_b[XLEN-1];
        w_b_zero   = (op_b == {XLEN{1'b0}});
        w_mag_a    = neg_word(op_a, w_sa);
        w_mag_b    = neg_word(op_b, w_sb);
        if (funct3[1]) begin
            w_divz_res = op_a;
        end else begin
            w_divz_res = {XLEN{1'b1}};
        end
    end

    // One shift-add step: multiplier sits in the low half and is consumed LSB first
    always_comb begin
        w_mul_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]};
        if (r_prod[0]) begin
            w_mul_sum = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, r_mag_a};
        end else begin
            w_mul_sum = {1'b0, r_prod[2*XLEN-1:XLEN]};
        end
        w_mul_next = {w_mul_sum, r_prod[XLEN-1:1]};
    end

    // One restoring-division step; the borrow bit of the trial subtract decides the quotient bit
    always_comb begin
        w_div_trial = {r_rem, r_quo[XLEN-1]};
        w_div_diff  = w_div_trial - {1'b0, r_mag_b};
        w_div_ge    = ~w_div_diff[XLEN];
        if (w_div_ge) begin
            w_rem_next = w_div_diff[XLEN-1:0];
        end else begin
            w_rem_next = w_div_trial[XLEN-1:0];
        end
        w_quo_next = {r_quo[XLEN-2:0], w_div_ge};
    end

    // Sign fix and output word selection
    always_comb begin
        w_prod_fix = neg_dword(r_prod, r_neg_p);
        w_quo_fix  = neg_word(r_quo, r_neg_q);
        w_rem_fix  = neg_word(r_rem, r_neg_r);
        w_fix_sel  = {XLEN{1'b0}};
        case (r_funct3)
            3'b000:                 w_fix_sel = w_prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_sel = w_prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_sel = w_quo_fix;
            3'b110, 3'b111:         w_fix_sel = w_rem_fix;
            default:                w_fix_sel = {XLEN{1'b0}};
        endcase
    end

    // Sequencer FSM with registered busy/done/result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_funct3 <= 3'd0;
            r_mag_a  <= {XLEN{1'b0}};
            r_mag_b  <= {XLEN{1'b0}};
            r_prod   <= {(2*XLEN){1'b0}};
            r_quo    <= {XLEN{1'b0}};
            r_rem    <= {XLEN{1'b0}};
            r_neg_p  <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_cnt    <= {CW{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= {XLEN{1'b0}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !kill) begin
                        r_funct3 <= funct3;
                        r_mag_a  <= w_mag_a;
                        r_mag_b  <= w_mag_b;
                        r_prod   <= {{XLEN{1'b0}}, w_mag_b};
                        r_quo    <= w_mag_a;
                        r_rem    <= {XLEN{1'b0}};
                        r_neg_p  <= w_sa ^ w_sb;
                        // A zero divisor keeps the all-ones quotient unsigned
                        r_neg_q  <= (w_sa ^ w_sb) & ~w_b_zero;
                        r_neg_r  <= w_sa;
                        r_cnt    <= {CW{1'b0}};
                        if (!funct3[2]) begin
                            r_state <= S_MUL;
                            r_busy  <= 1'b1;
                        end else if (w_b_zero && DIVZ_FAST) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_result <= w_divz_res;
                        end else begin
                            r_state <= S_DIV;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    if (kill) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_prod <= w_mul_next;
                        r_cnt  <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                        if (r_cnt == LAST_ITER) begin
                            r_state <= S_FIX;
                        end else begin
                            r_state <= S_MUL;
                        end
                    end
                end
                S_DIV: begin
                    if (kill) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_quo <= w_quo_next;
                        r_rem <= w_rem_next;
                        r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                        if (r_cnt == LAST_ITER) begin
                            r_state <= S_FIX;
                        end else begin
                            r_state <= S_DIV;
                        end
                    end
                end
                S_FIX: begin
                    r_busy <= 1'b0;
                    if (kill) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_result <= w_fix_sel;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign result  = r_result;
    assign stall_o = (start & ~kill & (r_state == S_IDLE)) | r_busy;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed corner cases, kill/reset aborts
// and randomized operations checked against a plain-arithmetic reference model.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        kill;
    logic        busy;
    logic        stall_o;
    logic        done;
    logic [31:0] result;

    muldiv_sequencer #(.XLEN(32), .DIVZ_FAST(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a),
        .op_b(op_b), .kill(kill), .busy(busy), .stall_o(stall_o), .done(done),
        .result(result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        logic [2:0]  f3;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          errors = 0;
    logic [31:0] last_res = 32'd0;

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sbv = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        longint p;
        logic   ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = ua * ub;  return p[31:0];  end
            3'd1: begin p = sa * sbv; return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sbv; return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                p = sa % sbv; return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            tests++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done at cycle %0d result=%h", cyc, result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (result !== e.res || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL op f3=%0d: got result=%h at cycle %0d, expected %h at cycle %0d",
                             e.f3, result, cyc, e.res, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   lat;
        bit   st_ok;
        bit   got;
        @(posedge clk); #1;
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        lat = (f[2] && b == 32'd0) ? 1 : 34;
        e.res = ref_model(f, a, b); e.cyc = cyc + lat; e.f3 = f;
        sb.push_back(e);
        last_res = e.res;
        st_ok = 1'b1;
        @(negedge clk);
        if (!stall_o) st_ok = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                if (stall_o) st_ok = 1'b0;
            end else if (!stall_o) begin
                st_ok = 1'b0;
            end
        end
        tests++;
        if (!got) begin
            errors++;
            $display("FAIL timeout f3=%0d a=%h b=%h: no done within 60 cycles", f, a, b);
        end
        tests++;
        if (!st_ok) begin
            errors++;
            $display("FAIL stall_profile f3=%0d a=%h b=%h: stall_o not high from launch until done", f, a, b);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [6];
        corners[0] = 32'd0;          corners[1] = 32'd1;
        corners[2] = 32'hFFFF_FFFF;  corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;  corners[5] = 32'd7;
        if ($urandom_range(3, 0) == 0) return corners[$urandom_range(5, 0)];
        return $urandom;
    endfunction

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        issue(3'd0, 32'd7, 32'd6);
        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        issue(3'd3, 32'hFFFF_FFFF, 32'd2);
        issue(3'd2, 32'hFFFF_FFFF, 32'd2);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2);
        issue(3'd5, 32'd100, 32'd7);
        issue(3'd7, 32'd100, 32'd7);
        issue(3'd4, 32'd5, 32'd0);
        issue(3'd7, 32'd5, 32'd0);
        issue(3'd4, 32'hFFFF_FFFB, 32'd0);
        issue(3'd6, 32'hFFFF_FFFB, 32'd0);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // Kill a DIVU at cycle 10 of its life
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        @(negedge clk);
        check("kill_busy", {31'd0, busy}, 32'd0);
        check("kill_result_held", result, last_res);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("kill_no_done", 32'(seen), 32'd0);

        // Reset during cycle 20 of a MUL
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd0; op_a = 32'd12345; op_b = 32'd678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (18) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        last_res = 32'd0;
        @(negedge clk);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_result", result, 32'd0);

        // Start and kill in the same cycle
        @(posedge clk); #1;
        start = 1'b1; kill = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3;
        @(negedge clk);
        check("startkill_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy || done) seen++;
        end
        check("startkill_idle", 32'(seen), 32'd0);

        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(7, 0)), pick_operand(), pick_operand());
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
